// File: rtl/inv_mix_column.sv
// InvMixColumns applied in place to the 4x4 statemt RAM, one column per 5 cycles over both ports.
// Latency 1+5*NB cycles from accepted ap_start to ap_done; no backpressure, the RAM is always ready.
module inv_mix_column #(
   parameter int NB = 4,
   parameter int AW = 5,
   parameter int DW = 32
) (
   input  logic          ap_clk,
   input  logic          ap_rst_n,
   input  logic          ap_start,
   output logic          ap_done,
   output logic          ap_idle,
   output logic          ap_ready,
   output logic [AW-1:0] statemt_address0,
   output logic          statemt_ce0,
   output logic          statemt_we0,
   output logic [DW-1:0] statemt_d0,
   input  logic [DW-1:0] statemt_q0,
   output logic [AW-1:0] statemt_address1,
   output logic          statemt_ce1,
   output logic          statemt_we1,
   output logic [DW-1:0] statemt_d1,
   input  logic [DW-1:0] statemt_q1
);

   typedef enum logic [5:0] {
      IDLE = 6'b000001,
      CHK  = 6'b000010,
      RD   = 6'b000100,
      CAP  = 6'b001000,
      WR0  = 6'b010000,
      WR1  = 6'b100000
   } state_t;

   state_t     state, state_nxt;
   logic [2:0] j;
   logic [7:0] a0, a1, a2, a3;
   logic [7:0] r0, r1, r2, r3;
   logic [1:0] row0, row1;
   logic       done, idle;
   logic [7:0] q0_b, q1_b;
   logic       unused_q;

   assign q0_b     = statemt_q0[7:0];
   assign q1_b     = statemt_q1[7:0];
   assign unused_q = ^{statemt_q0[DW-1:8], statemt_q1[DW-1:8]};

   function automatic logic [7:0] xt(input logic [7:0] x);
      return {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
   endfunction

   // Coefficients are constants, so each call folds to a few XORs of the xt chain.
   function automatic logic [7:0] gmul(input logic [7:0] x, input logic [3:0] c);
      logic [7:0] x2, x4, x8;
      x2 = xt(x);
      x4 = xt(x2);
      x8 = xt(x4);
      return (c[0] ? x : 8'h00) ^ (c[1] ? x2 : 8'h00) ^
             (c[2] ? x4 : 8'h00) ^ (c[3] ? x8 : 8'h00);
   endfunction

   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         state <= IDLE;
         j     <= 3'd0;
         a0    <= 8'h00;
         a1    <= 8'h00;
         a2    <= 8'h00;
         a3    <= 8'h00;
         r0    <= 8'h00;
         r1    <= 8'h00;
         r2    <= 8'h00;
         r3    <= 8'h00;
      end else begin
         state <= state_nxt;
         case (state)
            IDLE: if (ap_start) j <= 3'd0;
            RD: begin
               a0 <= q0_b;
               a1 <= q1_b;
            end
            CAP: begin
               // a2/a3 arrive on the q ports this cycle, so use them live
               a2 <= q0_b;
               a3 <= q1_b;
               r0 <= gmul(a0, 4'hE) ^ gmul(a1, 4'hB) ^ gmul(q0_b, 4'hD) ^ gmul(q1_b, 4'h9);
               r1 <= gmul(a0, 4'h9) ^ gmul(a1, 4'hE) ^ gmul(q0_b, 4'hB) ^ gmul(q1_b, 4'hD);
               r2 <= gmul(a0, 4'hD) ^ gmul(a1, 4'h9) ^ gmul(q0_b, 4'hE) ^ gmul(q1_b, 4'hB);
               r3 <= gmul(a0, 4'hB) ^ gmul(a1, 4'hD) ^ gmul(q0_b, 4'h9) ^ gmul(q1_b, 4'hE);
            end
            WR1: j <= j + 3'd1;
            default: ;
         endcase
      end
   end

   always_comb begin
      state_nxt   = state;
      done        = 1'b0;
      idle        = 1'b0;
      statemt_ce0 = 1'b0;
      statemt_we0 = 1'b0;
      statemt_ce1 = 1'b0;
      statemt_we1 = 1'b0;
      statemt_d0  = '0;
      statemt_d1  = '0;
      row0        = 2'd0;
      row1        = 2'd1;
      case (state)
         IDLE: begin
            idle = ~ap_start;
            if (ap_start) state_nxt = CHK;
         end
         CHK: begin
            if (j == 3'(NB)) begin
               done      = 1'b1;
               state_nxt = IDLE;
            end else begin
               statemt_ce0 = 1'b1;
               statemt_ce1 = 1'b1;
               state_nxt   = RD;
            end
         end
         RD: begin
            statemt_ce0 = 1'b1;
            statemt_ce1 = 1'b1;
            row0        = 2'd2;
            row1        = 2'd3;
            state_nxt   = CAP;
         end
         CAP: state_nxt = WR0;
         WR0: begin
            statemt_ce0 = 1'b1;
            statemt_we0 = 1'b1;
            statemt_ce1 = 1'b1;
            statemt_we1 = 1'b1;
            statemt_d0  = DW'(r0);
            statemt_d1  = DW'(r1);
            state_nxt   = WR1;
         end
         WR1: begin
            statemt_ce0 = 1'b1;
            statemt_we0 = 1'b1;
            statemt_ce1 = 1'b1;
            statemt_we1 = 1'b1;
            statemt_d0  = DW'(r2);
            statemt_d1  = DW'(r3);
            row0        = 2'd2;
            row1        = 2'd3;
            state_nxt   = CHK;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign statemt_address0 = AW'({j, row0});
   assign statemt_address1 = AW'({j, row1});
   assign ap_done          = done;
   assign ap_ready         = done;
   // ap_start is not sampled in reset, so idle must read 0 there too
   assign ap_idle          = idle & ap_rst_n;

endmodule

// File: tb/tb_inv_mix_column.sv
// Bench for inv_mix_column: dual-port RAM model, table vectors, random states against a GF(2^8) matrix model,
// handshake/trace checks, back-to-back start and reset abort.
module tb_inv_mix_column;
   localparam int NB = 4;
   localparam int AW = 5;
   localparam int DW = 32;

   logic          ap_clk = 1'b0;
   logic          ap_rst_n;
   logic          ap_start;
   logic          ap_done, ap_idle, ap_ready;
   logic [AW-1:0] statemt_address0, statemt_address1;
   logic          statemt_ce0, statemt_we0, statemt_ce1, statemt_we1;
   logic [DW-1:0] statemt_d0, statemt_d1, statemt_q0, statemt_q1;

   logic [31:0]   mem [0:31];
   logic          ld_en;
   logic [4:0]    ld_addr;
   logic [31:0]   ld_dat;

   int n_checks = 0;
   int n_pass   = 0;

   typedef struct packed {
      logic [511:0] init;
      logic [511:0] expv;
   } vec_t;
   vec_t vecs [3];

   inv_mix_column #(.NB(NB), .AW(AW), .DW(DW)) dut (
      .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .ap_start(ap_start),
      .ap_done(ap_done), .ap_idle(ap_idle), .ap_ready(ap_ready),
      .statemt_address0(statemt_address0), .statemt_ce0(statemt_ce0),
      .statemt_we0(statemt_we0), .statemt_d0(statemt_d0), .statemt_q0(statemt_q0),
      .statemt_address1(statemt_address1), .statemt_ce1(statemt_ce1),
      .statemt_we1(statemt_we1), .statemt_d1(statemt_d1), .statemt_q1(statemt_q1)
   );

   always #5 ap_clk = ~ap_clk;

   always @(posedge ap_clk) begin
      if (ld_en) mem[ld_addr] <= ld_dat;
      if (statemt_ce0) begin
         if (statemt_we0) mem[statemt_address0] <= statemt_d0;
         else statemt_q0 <= mem[statemt_address0];
      end
      if (statemt_ce1) begin
         if (statemt_we1) mem[statemt_address1] <= statemt_d1;
         else statemt_q1 <= mem[statemt_address1];
      end
   end

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      logic [7:0] aa = a;
      logic [7:0] bb = b;
      for (int k = 0; k < 8; k++) begin
         if (bb[0]) p = p ^ aa;
         aa = aa[7] ? ((aa << 1) ^ 8'h1B) : (aa << 1);
         bb = bb >> 1;
      end
      return p;
   endfunction

   // Circulant InvMixColumns matrix applied to the low byte of each word.
   function automatic logic [511:0] model(input logic [511:0] st);
      logic [7:0]   base [4];
      logic [7:0]   a [4];
      logic [7:0]   r;
      logic [511:0] o = '0;
      base = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
      for (int c = 0; c < 4; c++) begin
         for (int k = 0; k < 4; k++) a[k] = st[(c*4+k)*32 +: 8];
         for (int i = 0; i < 4; i++) begin
            r = 8'h00;
            for (int k = 0; k < 4; k++) r = r ^ gf_mul(base[(k - i + 4) % 4], a[k]);
            o[(c*4+i)*32 +: 32] = {24'h0, r};
         end
      end
      return o;
   endfunction

   function automatic logic [511:0] put(input logic [511:0] v, input int a, input logic [31:0] w);
      logic [511:0] o = v;
      o[a*32 +: 32] = w;
      return o;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic load_state(input logic [511:0] st);
      for (int i = 0; i < 16; i++) begin
         ld_en   = 1'b1;
         ld_addr = 5'(i);
         ld_dat  = st[i*32 +: 32];
         @(negedge ap_clk);
      end
      ld_en = 1'b0;
   endtask

   task automatic check_state(input string tag, input logic [511:0] exp);
      for (int i = 0; i < 16; i++)
         check($sformatf("%s_w%0d", tag, i), mem[i], exp[i*32 +: 32]);
   endtask

   function automatic logic [511:0] snapshot();
      logic [511:0] o;
      for (int i = 0; i < 16; i++) o[i*32 +: 32] = mem[i];
      return o;
   endfunction

   // Called at a negedge with the DUT idle; start is asserted in cycle 0.
   task automatic run_op(input int drop_at, output int first_done, output int last_done,
                         output int n_done, output logic [31:0] ce0_tr, output logic [31:0] ce1_tr,
                         output logic [31:0] we0_tr, output logic [31:0] we1_tr,
                         output logic rdy_ok, output logic conf_ok);
      ap_start = 1'b1;
      #1;
      check("idle_drop_at_start", {31'b0, ap_idle}, 32'd0);
      first_done = -1; last_done = -1; n_done = 0;
      ce0_tr = '0; ce1_tr = '0; we0_tr = '0; we1_tr = '0;
      rdy_ok = 1'b1; conf_ok = 1'b1;
      for (int c = 1; c <= 50; c++) begin
         @(negedge ap_clk);
         if (c >= drop_at) ap_start = 1'b0;
         #1;
         if (c < 32) begin
            ce0_tr[c] = statemt_ce0; ce1_tr[c] = statemt_ce1;
            we0_tr[c] = statemt_we0; we1_tr[c] = statemt_we1;
         end
         if (ap_done === 1'b1) begin
            n_done++;
            if (first_done < 0) first_done = c;
            last_done = c;
         end
         if (ap_ready !== ap_done) rdy_ok = 1'b0;
         if (statemt_ce0 && statemt_ce1 && statemt_address0 == statemt_address1) conf_ok = 1'b0;
      end
      @(negedge ap_clk);
   endtask

   initial begin
      int           fd, ldn, nd;
      logic [31:0]  c0t, c1t, w0t, w1t, exp_ce, exp_we;
      logic         rok, cok, seen_done;
      logic [511:0] st, expst, snap;

      exp_ce = '0; exp_we = '0;
      for (int c = 1; c <= 5*NB; c++) begin
         exp_ce[c] = ((c - 1) % 5) != 2;
         exp_we[c] = ((c - 1) % 5) >= 3;
      end

      vecs[0].init = put(put(put(put('0, 0, 32'h8e), 1, 32'h4d), 2, 32'ha1), 3, 32'hbc);
      vecs[0].expv = put(put(put(put('0, 0, 32'hdb), 1, 32'h13), 2, 32'h53), 3, 32'h45);
      st = put(put(put(put('0, 0, 32'h9f), 1, 32'hdc), 2, 32'h58), 3, 32'h9d);
      st = put(put(put(put(st, 12, 32'hd5), 13, 32'hd5), 14, 32'hd7), 15, 32'hd6);
      expst = put(put(put(put('0, 0, 32'hf2), 1, 32'h0a), 2, 32'h22), 3, 32'h5c);
      expst = put(put(put(put(expst, 12, 32'hd4), 13, 32'hd4), 14, 32'hd4), 15, 32'hd5);
      for (int i = 4; i < 8; i++) begin
         st = put(st, i, 32'hc6);      expst = put(expst, i, 32'hc6);
         st = put(st, i + 4, 32'h01);  expst = put(expst, i + 4, 32'h01);
      end
      vecs[1].init = st;
      vecs[1].expv = expst;
      vecs[2].init = put(put(put(put('0, 0, 32'hFFFFFF8E), 1, 32'hABCD004D), 2, 32'h000001A1), 3, 32'h123456BC);
      vecs[2].expv = vecs[0].expv;

      ap_rst_n = 1'b0; ap_start = 1'b0; ld_en = 1'b0; ld_addr = '0; ld_dat = '0;
      #12;
      check("rst_idle", {31'b0, ap_idle}, 32'd0);
      check("rst_outs", {28'b0, ap_done, ap_ready, statemt_ce0, statemt_ce1}, 32'd0);
      @(negedge ap_clk);
      ap_rst_n = 1'b1;
      @(negedge ap_clk);
      check("idle_before_start", {31'b0, ap_idle}, 32'd1);

      for (int v = 0; v < 3; v++) begin
         load_state(vecs[v].init);
         run_op(1, fd, ldn, nd, c0t, c1t, w0t, w1t, rok, cok);
         check($sformatf("v%0d_done_cycle", v), 32'(fd), 32'd21);
         check($sformatf("v%0d_done_count", v), 32'(nd), 32'd1);
         check_state($sformatf("v%0d", v), vecs[v].expv);
         if (v == 0) begin
            check("trace_ce0", c0t, exp_ce);
            check("trace_ce1", c1t, exp_ce);
            check("trace_we0", w0t, exp_we);
            check("trace_we1", w1t, exp_we);
            check("ready_eq_done", {31'b0, rok}, 32'd1);
            check("port_no_conflict", {31'b0, cok}, 32'd1);
         end
      end

      for (int t = 0; t < 12; t++) begin
         for (int i = 0; i < 16; i++) st[i*32 +: 32] = $urandom();
         load_state(st);
         run_op(1, fd, ldn, nd, c0t, c1t, w0t, w1t, rok, cok);
         check($sformatf("rnd%0d_done_cycle", t), 32'(fd), 32'd21);
         check($sformatf("rnd%0d_ready", t), {30'b0, rok, cok}, 32'd3);
         check_state($sformatf("rnd%0d", t), model(st));
      end

      // ap_start held through the return to IDLE: second run begins immediately.
      load_state(vecs[0].init);
      run_op(23, fd, ldn, nd, c0t, c1t, w0t, w1t, rok, cok);
      check("b2b_first_done", 32'(fd), 32'd21);
      check("b2b_second_done", 32'(ldn), 32'd43);
      check("b2b_done_count", 32'(nd), 32'd2);
      check_state("b2b", model(model(vecs[0].init)));

      // Reset during column 2's RD cycle aborts the run.
      for (int i = 0; i < 16; i++) st[i*32 +: 32] = $urandom();
      load_state(st);
      ap_start = 1'b1;
      seen_done = 1'b0;
      for (int c = 1; c <= 12; c++) begin
         @(negedge ap_clk);
         ap_start = 1'b0;
         if (ap_done === 1'b1) seen_done = 1'b1;
      end
      #1;
      check("abort_ce_before", {30'b0, statemt_ce0, statemt_ce1}, 32'd3);
      ap_rst_n = 1'b0;
      #1;
      check("abort_ce_we_drop", {28'b0, statemt_ce0, statemt_ce1, statemt_we0, statemt_we1}, 32'd0);
      for (int c = 0; c < 4; c++) begin
         @(negedge ap_clk);
         if (ap_done !== 1'b0 || statemt_ce0 !== 1'b0 || statemt_ce1 !== 1'b0) seen_done = 1'b1;
      end
      ap_rst_n = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge ap_clk);
         if (ap_done !== 1'b0) seen_done = 1'b1;
      end
      check("abort_quiet", {31'b0, seen_done}, 32'd0);
      expst = model(st);
      for (int i = 8; i < 16; i++) expst[i*32 +: 32] = st[i*32 +: 32];
      check_state("abort", expst);
      snap = snapshot();
      run_op(1, fd, ldn, nd, c0t, c1t, w0t, w1t, rok, cok);
      check("post_abort_done_cycle", 32'(fd), 32'd21);
      check_state("post_abort", model(snap));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
